// File: rtl/dflow_replay_ctrl_if.sv
// Command, core-handshake and status bundle between the register block
// (master side) and the dflow replay run-control sequencer (slave side).
`timescale 1ns/1ps

interface dflow_replay_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    // register block / core -> sequencer
    logic                 init_calib_complete;
    logic                 cmd_store;
    logic                 cmd_replay;
    logic                 cmd_abort;
    logic                 tuple_in_fire;
    logic                 tuple_out_fire;
    logic                 compelete_replay;

    // sequencer -> core / register block
    logic                 sw_rst;
    logic                 start_store;
    logic                 start_replay;
    logic [2:0]           state;
    logic                 busy;
    logic                 done;
    logic [1:0]           err;
    logic [CNT_WIDTH-1:0] stored_cnt;
    logic [CNT_WIDTH-1:0] replayed_cnt;

    modport master (
        output init_calib_complete, cmd_store, cmd_replay, cmd_abort,
               tuple_in_fire, tuple_out_fire, compelete_replay,
        input  sw_rst, start_store, start_replay, state, busy, done, err,
               stored_cnt, replayed_cnt
    );

    modport slave (
        input  init_calib_complete, cmd_store, cmd_replay, cmd_abort,
               tuple_in_fire, tuple_out_fire, compelete_replay,
        output sw_rst, start_store, start_replay, state, busy, done, err,
               stored_cnt, replayed_cnt
    );
endinterface

// File: rtl/dflow_replay_ctrl.sv
// Run-control sequencer for the dflow 5-tuple generator core. Turns host
// store/replay/abort pulses into the core's sw_rst/start_store/start_replay
// levels, ends a capture on idle timeout or tuple quota, waits for the
// core's replay-complete flag, and keeps status counters and sticky errors.
// Every output is driven straight from a flop.
`timescale 1ns/1ps

module dflow_replay_ctrl #(
    parameter int          SW_RST_CYCLES = 8,
    parameter int          IDLE_TIMEOUT  = 1024,
    parameter logic [31:0] MAX_STORE     = 32'hFFFF_FFFF,
    parameter int          CNT_WIDTH     = 32
) (
    input  logic               qdr_clk,
    input  logic               resetn,
    dflow_replay_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_WAIT_CAL = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RST      = 3'd2,
        ST_STORE    = 3'd3,
        ST_REPLAY   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [7:0]           RST_LAST   = 8'(SW_RST_CYCLES - 1);
    localparam logic [31:0]          IDLE_LIMIT = 32'(IDLE_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] QUOTA      = CNT_WIDTH'(MAX_STORE);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // States in which the core is being driven by this sequencer.
    function automatic logic is_busy(input state_t st);
        return (st == ST_RST) || (st == ST_STORE) || (st == ST_REPLAY);
    endfunction

    state_t               state_r,        state_s;
    logic                 sw_rst_r,       sw_rst_s;
    logic                 start_store_r,  start_store_s;
    logic                 start_replay_r, start_replay_s;
    logic                 busy_r,         busy_s;
    logic                 done_r,         done_s;
    logic [1:0]           err_r,          err_s;
    logic [CNT_WIDTH-1:0] stored_cnt_r,   stored_cnt_s;
    logic [CNT_WIDTH-1:0] replayed_cnt_r, replayed_cnt_s;
    logic [31:0]          idle_cnt_r,     idle_cnt_s;
    logic [7:0]           rst_cnt_r,      rst_cnt_s;
    logic                 replay_first_r, replay_first_s;

    logic [CNT_WIDTH-1:0] stored_inc_s;
    logic [CNT_WIDTH-1:0] replayed_inc_s;
    logic [31:0]          idle_inc_s;

    // Next-state, next-counter and next-output decode; priority is
    // calibration loss, then abort, then run-ending events, then commands.
    always_comb begin
        state_s        = state_r;
        err_s          = err_r;
        stored_cnt_s   = stored_cnt_r;
        replayed_cnt_s = replayed_cnt_r;
        idle_cnt_s     = idle_cnt_r;
        rst_cnt_s      = rst_cnt_r;
        replay_first_s = 1'b0;
        stored_inc_s   = sat_inc(stored_cnt_r);
        replayed_inc_s = sat_inc(replayed_cnt_r);
        idle_inc_s     = idle_cnt_r + 32'd1;

        if (!bus.init_calib_complete && (state_r != ST_WAIT_CAL)) begin
            // Calibration lost: park everything, flag it if a run was live.
            state_s    = ST_WAIT_CAL;
            idle_cnt_s = 32'd0;
            rst_cnt_s  = 8'd0;
            if (is_busy(state_r)) begin
                err_s[1] = 1'b1;
            end else begin
                err_s[1] = err_r[1];
            end
        end else if (bus.cmd_abort && is_busy(state_r)) begin
            // Abort keeps the counters so software can see how far it got.
            state_s    = ST_IDLE;
            idle_cnt_s = 32'd0;
            rst_cnt_s  = 8'd0;
        end else begin
            case (state_r)
                ST_WAIT_CAL: begin
                    if (bus.init_calib_complete) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT_CAL;
                    end
                end

                ST_IDLE: begin
                    if (bus.cmd_abort) begin
                        state_s = ST_IDLE;
                    end else if (bus.cmd_store) begin
                        state_s      = ST_RST;
                        stored_cnt_s = CNT_ZERO;
                        err_s        = 2'b00;
                        rst_cnt_s    = 8'd0;
                        idle_cnt_s   = 32'd0;
                    end else if (bus.cmd_replay) begin
                        if (stored_cnt_r != CNT_ZERO) begin
                            state_s        = ST_REPLAY;
                            replayed_cnt_s = CNT_ZERO;
                            replay_first_s = 1'b1;
                        end else begin
                            err_s[0] = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end

                ST_RST: begin
                    if (rst_cnt_r == RST_LAST) begin
                        state_s    = ST_STORE;
                        rst_cnt_s  = 8'd0;
                        idle_cnt_s = 32'd0;
                    end else begin
                        rst_cnt_s = rst_cnt_r + 8'd1;
                    end
                end

                ST_STORE: begin
                    if (bus.tuple_in_fire) begin
                        stored_cnt_s = stored_inc_s;
                        idle_cnt_s   = 32'd0;
                        if (stored_inc_s == QUOTA) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_STORE;
                        end
                    end else if (stored_cnt_r != CNT_ZERO) begin
                        // Idle timer only arms after the first accepted tuple.
                        idle_cnt_s = idle_inc_s;
                        if (idle_inc_s == IDLE_LIMIT) begin
                            state_s    = ST_DONE;
                            idle_cnt_s = 32'd0;
                        end else begin
                            state_s = ST_STORE;
                        end
                    end else begin
                        state_s = ST_STORE;
                    end
                end

                ST_REPLAY: begin
                    if (bus.tuple_out_fire) begin
                        replayed_cnt_s = replayed_inc_s;
                    end else begin
                        replayed_cnt_s = replayed_cnt_r;
                    end
                    // The core's complete flag is stale on the first cycle.
                    if (bus.compelete_replay && !replay_first_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REPLAY;
                    end
                end

                ST_DONE: begin
                    state_s = ST_IDLE;
                end

                default: begin
                    state_s = ST_WAIT_CAL;
                end
            endcase
        end

        sw_rst_s       = (state_s == ST_RST);
        start_store_s  = (state_s == ST_STORE);
        start_replay_s = (state_s == ST_REPLAY);
        busy_s         = is_busy(state_s);
        done_s         = (state_s == ST_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge qdr_clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_WAIT_CAL;
            sw_rst_r       <= 1'b0;
            start_store_r  <= 1'b0;
            start_replay_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 2'b00;
            stored_cnt_r   <= CNT_ZERO;
            replayed_cnt_r <= CNT_ZERO;
            idle_cnt_r     <= 32'd0;
            rst_cnt_r      <= 8'd0;
            replay_first_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            sw_rst_r       <= sw_rst_s;
            start_store_r  <= start_store_s;
            start_replay_r <= start_replay_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            err_r          <= err_s;
            stored_cnt_r   <= stored_cnt_s;
            replayed_cnt_r <= replayed_cnt_s;
            idle_cnt_r     <= idle_cnt_s;
            rst_cnt_r      <= rst_cnt_s;
            replay_first_r <= replay_first_s;
        end
    end

    assign bus.state        = state_r;
    assign bus.sw_rst       = sw_rst_r;
    assign bus.start_store  = start_store_r;
    assign bus.start_replay = start_replay_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.stored_cnt   = stored_cnt_r;
    assign bus.replayed_cnt = replayed_cnt_r;

endmodule

// File: tb/tb_dflow_replay_ctrl.sv
// Self-checking bench for dflow_replay_ctrl: a command table for the
// IDLE/WAIT_CAL decisions, randomized store/replay runs whose expected
// enable durations and counts are computed from gap lists, and directed
// sequences for quota, abort, calibration loss and async reset.
`timescale 1ns/1ps

module tb_dflow_replay_ctrl;

    localparam int CW = 32;
    localparam int RSTC = 4;
    localparam int TMO = 16;

    logic qdr_clk = 1'b0;
    logic resetn  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 qdr_clk = ~qdr_clk;

    dflow_replay_ctrl_if #(.CNT_WIDTH(CW)) bus_a ();
    dflow_replay_ctrl_if #(.CNT_WIDTH(CW)) bus_q ();

    dflow_replay_ctrl #(.SW_RST_CYCLES(RSTC), .IDLE_TIMEOUT(TMO),
                        .MAX_STORE(32'hFFFF_FFFF), .CNT_WIDTH(CW))
        dut_a (.qdr_clk(qdr_clk), .resetn(resetn), .bus(bus_a));

    dflow_replay_ctrl #(.SW_RST_CYCLES(RSTC), .IDLE_TIMEOUT(TMO),
                        .MAX_STORE(32'd5), .CNT_WIDTH(CW))
        dut_q (.qdr_clk(qdr_clk), .resetn(resetn), .bus(bus_q));

    // Free-running high-cycle counters, sampled on the falling edge.
    int mon_sw_a = 0, mon_store_a = 0, mon_done_a = 0;
    int mon_store_q = 0, mon_done_q = 0;
    always @(negedge qdr_clk) begin
        if (bus_a.sw_rst)      mon_sw_a    <= mon_sw_a + 1;
        if (bus_a.start_store) mon_store_a <= mon_store_a + 1;
        if (bus_a.done)        mon_done_a  <= mon_done_a + 1;
        if (bus_q.start_store) mon_store_q <= mon_store_q + 1;
        if (bus_q.done)        mon_done_q  <= mon_done_q + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge qdr_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_a(input logic [2:0] tgt, input int budget, input string nm);
        int n = 0;
        while (bus_a.state != tgt && n < budget) begin
            tick();
            n++;
        end
        chk(nm, {61'd0, bus_a.state}, {61'd0, tgt});
    endtask

    // Capture n tuples; expected start_store duration is the sum of
    // (gap+1) per tuple plus the idle timeout after the last one.
    task automatic do_store(input int n, input int first_gap, input int max_gap);
        int s0, t0, d0, g, exp_hi;
        s0 = mon_sw_a; t0 = mon_store_a; d0 = mon_done_a; exp_hi = 0;
        bus_a.cmd_store = 1'b1; tick(); bus_a.cmd_store = 1'b0;
        chk("store_enter_rst", {61'd0, bus_a.state}, 64'd2);
        wait_a(3'd3, 20, "rst_to_store");
        for (int i = 0; i < n; i++) begin
            g = (i == 0) ? first_gap : int'($urandom_range(max_gap, 0));
            repeat (g) tick();
            bus_a.tuple_in_fire = 1'b1; tick(); bus_a.tuple_in_fire = 1'b0;
            exp_hi += g + 1;
        end
        exp_hi += TMO;
        wait_a(3'd1, 200, "store_timeout_exit");
        tick();
        chk("sw_rst_cycles", 64'(mon_sw_a - s0), 64'(RSTC));
        chk("start_store_cycles", 64'(mon_store_a - t0), 64'(exp_hi));
        chk("store_done_pulses", 64'(mon_done_a - d0), 64'd1);
        chk("stored_cnt", 64'(bus_a.stored_cnt), 64'(n));
        chk("store_err_clear", {62'd0, bus_a.err}, 64'd0);
    endtask

    // Replay m tuples; optional stale complete flag on the first cycle and
    // optional fire on the exit cycle (which must be counted).
    task automatic do_replay(input int m, input bit stale, input bit fire_exit);
        int d0;
        d0 = mon_done_a;
        bus_a.compelete_replay = stale;
        bus_a.cmd_replay = 1'b1; tick(); bus_a.cmd_replay = 1'b0;
        chk("replay_enter", {61'd0, bus_a.state}, 64'd4);
        chk("replayed_cleared", 64'(bus_a.replayed_cnt), 64'd0);
        if (stale) begin
            tick();
            bus_a.compelete_replay = 1'b0;
            chk("stale_complete_ignored", {61'd0, bus_a.state}, 64'd4);
        end
        for (int i = 0; i < m; i++) begin
            repeat ($urandom_range(3, 0)) tick();
            bus_a.tuple_out_fire = 1'b1; tick(); bus_a.tuple_out_fire = 1'b0;
        end
        bus_a.compelete_replay = 1'b1; bus_a.tuple_out_fire = fire_exit;
        tick();
        bus_a.compelete_replay = 1'b0; bus_a.tuple_out_fire = 1'b0;
        chk("replay_to_done", {61'd0, bus_a.state}, 64'd5);
        chk("replay_done_out", {63'd0, bus_a.done}, 64'd1);
        chk("start_replay_drop", {63'd0, bus_a.start_replay}, 64'd0);
        tick();
        chk("replay_back_idle", {61'd0, bus_a.state}, 64'd1);
        chk("replayed_cnt", 64'(bus_a.replayed_cnt), 64'(m + int'(fire_exit)));
        chk("replay_done_pulses", 64'(mon_done_a - d0), 64'd1);
    endtask

    typedef struct {
        bit       cal;
        bit       st;
        bit       rp;
        bit       ab;
        int       exp_state;
        bit [1:0] exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int d0, t0;

        // Expected results for single-cycle command decisions from IDLE.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 2'b01};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2'b01};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2'b01};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 2'b01};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 2'b01};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 2'b00};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 2'b00};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 2'b00};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 2'b00};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2'b10};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2'b10};

        bus_a.init_calib_complete = 1'b0; bus_a.cmd_store = 1'b0;
        bus_a.cmd_replay = 1'b0; bus_a.cmd_abort = 1'b0;
        bus_a.tuple_in_fire = 1'b0; bus_a.tuple_out_fire = 1'b0;
        bus_a.compelete_replay = 1'b0;
        bus_q.init_calib_complete = 1'b1; bus_q.cmd_store = 1'b0;
        bus_q.cmd_replay = 1'b0; bus_q.cmd_abort = 1'b0;
        bus_q.tuple_in_fire = 1'b0; bus_q.tuple_out_fire = 1'b0;
        bus_q.compelete_replay = 1'b0;

        // Reset state.
        #23;
        chk("rst_state", {61'd0, bus_a.state}, 64'd0);
        chk("rst_outputs", {58'd0, bus_a.sw_rst, bus_a.start_store, bus_a.start_replay,
                            bus_a.busy, bus_a.done, |bus_a.err}, 64'd0);
        chk("rst_counters", 64'(bus_a.stored_cnt | bus_a.replayed_cnt), 64'd0);
        resetn = 1'b1;

        // Calibration arrives after five cycles of waiting.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_cal_hold", {58'd0, bus_a.state, bus_a.start_store,
                                  bus_a.start_replay, bus_a.sw_rst}, 64'd0);
        end
        bus_a.init_calib_complete = 1'b1;
        tick();
        chk("cal_to_idle", {61'd0, bus_a.state}, 64'd1);

        // Command table.
        for (int i = 0; i < 12; i++) begin
            bus_a.init_calib_complete = vecs[i].cal;
            bus_a.cmd_store = vecs[i].st; bus_a.cmd_replay = vecs[i].rp;
            bus_a.cmd_abort = vecs[i].ab;
            tick();
            bus_a.cmd_store = 1'b0; bus_a.cmd_replay = 1'b0; bus_a.cmd_abort = 1'b0;
            chk($sformatf("vec%0d_state", i), {61'd0, bus_a.state}, 64'(vecs[i].exp_state));
            chk($sformatf("vec%0d_err", i), {62'd0, bus_a.err}, {62'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_sw_busy", i), {62'd0, bus_a.sw_rst, bus_a.busy},
                (vecs[i].exp_state == 2) ? 64'd3 : 64'd0);
        end
        bus_a.init_calib_complete = 1'b1;

        // Ten back-to-back tuples then silence; then a 20-tuple replay.
        do_store(10, 0, 0);
        do_replay(20, 1'b0, 1'b0);

        // Randomized capture/replay sessions.
        for (int it = 0; it < 6; it++) begin
            do_store(int'($urandom_range(9, 1)), int'($urandom_range(40, 0)), TMO - 1);
            do_replay(int'($urandom_range(12, 1)), 1'($urandom_range(1, 0)),
                      1'($urandom_range(1, 0)));
        end

        // Quota of five ends the capture on the fifth fire.
        t0 = mon_store_q; d0 = mon_done_q;
        bus_q.cmd_store = 1'b1; tick(); bus_q.cmd_store = 1'b0;
        for (int n = 0; n < 20 && bus_q.state != 3'd3; n++) tick();
        chk("q_store_entered", {61'd0, bus_q.state}, 64'd3);
        bus_q.tuple_in_fire = 1'b1;
        repeat (4) tick();
        chk("q_before_quota", {61'd0, bus_q.state}, 64'd3);
        tick();
        chk("q_quota_exit", {61'd0, bus_q.state}, 64'd5);
        repeat (3) tick();
        bus_q.tuple_in_fire = 1'b0;
        tick();
        chk("q_stored_cnt", 64'(bus_q.stored_cnt), 64'd5);
        chk("q_state_idle", {61'd0, bus_q.state}, 64'd1);
        chk("q_store_cycles", 64'(mon_store_q - t0), 64'd5);
        chk("q_done_pulses", 64'(mon_done_q - d0), 64'd1);

        // Abort mid-store; a store command while busy is dropped.
        bus_a.cmd_store = 1'b1; tick(); bus_a.cmd_store = 1'b0;
        wait_a(3'd3, 20, "abort_store_enter");
        bus_a.tuple_in_fire = 1'b1; repeat (3) tick(); bus_a.tuple_in_fire = 1'b0;
        bus_a.cmd_store = 1'b1; tick(); bus_a.cmd_store = 1'b0;
        chk("busy_store_ignored", {61'd0, bus_a.state}, 64'd3);
        chk("busy_store_keeps_cnt", 64'(bus_a.stored_cnt), 64'd3);
        d0 = mon_done_a;
        bus_a.cmd_abort = 1'b1; tick(); bus_a.cmd_abort = 1'b0;
        chk("abort_store_idle", {61'd0, bus_a.state}, 64'd1);
        chk("abort_store_enables", {61'd0, bus_a.sw_rst, bus_a.start_store, bus_a.busy}, 64'd0);
        tick();
        chk("abort_store_no_done", 64'(mon_done_a - d0), 64'd0);
        chk("abort_store_cnt_kept", 64'(bus_a.stored_cnt), 64'd3);

        // Abort mid-replay.
        d0 = mon_done_a;
        bus_a.cmd_replay = 1'b1; tick(); bus_a.cmd_replay = 1'b0;
        chk("abort_replay_enter", {61'd0, bus_a.state}, 64'd4);
        bus_a.tuple_out_fire = 1'b1; repeat (2) tick(); bus_a.tuple_out_fire = 1'b0;
        bus_a.cmd_abort = 1'b1; tick(); bus_a.cmd_abort = 1'b0;
        chk("abort_replay_idle", {61'd0, bus_a.state}, 64'd1);
        chk("abort_replay_enable", {62'd0, bus_a.start_replay, bus_a.busy}, 64'd0);
        tick();
        chk("abort_replay_cnt", 64'(bus_a.replayed_cnt), 64'd2);
        chk("abort_replay_no_done", 64'(mon_done_a - d0), 64'd0);

        // Calibration loss together with abort during replay.
        bus_a.cmd_replay = 1'b1; tick(); bus_a.cmd_replay = 1'b0;
        chk("calloss_replay_enter", {61'd0, bus_a.state}, 64'd4);
        bus_a.init_calib_complete = 1'b0; bus_a.cmd_abort = 1'b1;
        tick();
        bus_a.cmd_abort = 1'b0;
        chk("calloss_wait_cal", {61'd0, bus_a.state}, 64'd0);
        chk("calloss_err", {62'd0, bus_a.err}, 64'd2);
        chk("calloss_enables", {62'd0, bus_a.start_replay, bus_a.busy}, 64'd0);
        bus_a.init_calib_complete = 1'b1;
        tick();
        chk("cal_restored_idle", {61'd0, bus_a.state}, 64'd1);

        // Asynchronous reset in the middle of a capture.
        bus_a.cmd_store = 1'b1; tick(); bus_a.cmd_store = 1'b0;
        wait_a(3'd3, 20, "areset_store_enter");
        bus_a.tuple_in_fire = 1'b1; repeat (2) tick(); bus_a.tuple_in_fire = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_state", {61'd0, bus_a.state}, 64'd0);
        chk("areset_outputs", {59'd0, bus_a.start_store, bus_a.sw_rst, bus_a.busy,
                               bus_a.done, |bus_a.err}, 64'd0);
        chk("areset_stored", 64'(bus_a.stored_cnt), 64'd0);
        #2;
        resetn = 1'b1;
        tick();
        chk("areset_recover_idle", {61'd0, bus_a.state}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
